ofdm_frame_scheduler: RTL

Sequences multi-symbol OFDM frames through the baseband modulator controller. Accepts a frame request (symbol count, inter-symbol gap), issues one go pulse per symbol, and tracks the controller's busy flag to detect symbol completion. Sits between the host/MAC request interface and the modulator controller. Provides per-symbol indexing, gap insertion, abort and a busy-handshake timeout.

---
 rtl/ofdm_frame_scheduler_pkg.sv | 18 +
 rtl/ofdm_frame_scheduler_if.sv | 35 +++
 rtl/ofdm_frame_scheduler_down_counter.sv | 27 ++
 rtl/ofdm_frame_scheduler.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ofdm_frame_scheduler_pkg.sv
// Shared types and default widths for the OFDM frame scheduler.
// Imported by the interface, the top level and the testbench.
package ofdm_frame_scheduler_pkg;

   localparam int SYM_W_DEF        = 8;
   localparam int GAP_W_DEF        = 8;
   localparam int BUSY_TIMEOUT_DEF = 15;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_GAP       = 3'd4,
      S_DONE      = 3'd5
   } sched_state_t;

endpackage

// File: rtl/ofdm_frame_scheduler_if.sv
// Host request and modulator-controller handshake bundle of the frame scheduler.
// The scheduler takes the slave side; the host/controller side takes master.
interface ofdm_frame_scheduler_if
   import ofdm_frame_scheduler_pkg::*;
#(
   parameter int SYM_W = SYM_W_DEF,
   parameter int GAP_W = GAP_W_DEF
);

   logic             frame_req;
   logic [SYM_W-1:0] frame_len;
   logic [GAP_W-1:0] gap_cycles;
   logic             abort;
   logic             ctrl_busy;
   logic             ctrl_go;
   logic             frame_ack;
   logic             frame_active;
   logic [SYM_W-1:0] sym_idx;
   logic             frame_done;
   logic             frame_aborted;
   logic             timeout_err;

   modport master (
      output frame_req, frame_len, gap_cycles, abort, ctrl_busy,
      input  ctrl_go, frame_ack, frame_active, sym_idx, frame_done,
             frame_aborted, timeout_err
   );

   modport slave (
      input  frame_req, frame_len, gap_cycles, abort, ctrl_busy,
      output ctrl_go, frame_ack, frame_active, sym_idx, frame_done,
             frame_aborted, timeout_err
   );

endinterface

// File: rtl/ofdm_frame_scheduler_down_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module ofdm_frame_scheduler_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/ofdm_frame_scheduler.sv
// Sequences multi-symbol OFDM frames: one ctrl_go per symbol, busy-flag tracking,
// inter-symbol gap, abort and busy-rise timeout. Every output is registered.
module ofdm_frame_scheduler
   import ofdm_frame_scheduler_pkg::*;
#(
   parameter int SYM_W        = SYM_W_DEF,
   parameter int GAP_W        = GAP_W_DEF,
   parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   ofdm_frame_scheduler_if.slave bus
);

   localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

   sched_state_t     r_state, w_state_nxt;
   logic [SYM_W-1:0] r_len, r_sym_idx, w_sym_idx_nxt;
   logic [GAP_W-1:0] r_gap;
   logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
   logic             r_abort_pend, w_abort_pend_nxt, w_abort_eff;
   logic             r_go, r_ack, r_active, r_done, r_aborted, r_tmo_err;
   logic             w_ack_nxt, w_tmo_err_nxt, w_last_sym;
   logic             w_gap_load, w_gap_dec, w_gap_zero;

   // Abort counts from the cycle it arrives, so a same-cycle final completion still reports it.
   assign w_abort_eff = r_abort_pend |
                        (bus.abort && (r_state != S_IDLE) && (r_state != S_DONE));
   assign w_last_sym  = (r_sym_idx == r_len - SYM_W'(1));

   // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_sym_idx_nxt = r_sym_idx;
      w_tmo_cnt_nxt = r_tmo_cnt;
      w_tmo_err_nxt = r_tmo_err;
      w_ack_nxt     = 1'b0;
      w_gap_load    = 1'b0;
      w_gap_dec     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.frame_req && (bus.frame_len != '0)) begin
               w_state_nxt   = S_LAUNCH;
               w_ack_nxt     = 1'b1;
               w_sym_idx_nxt = '0;
               w_tmo_err_nxt = 1'b0;
            end
         end
         S_LAUNCH: begin
            w_tmo_cnt_nxt = '0;
            w_state_nxt   = bus.abort ? S_DONE : S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (bus.ctrl_busy) begin
               w_state_nxt = S_WAIT_DONE;
            end else if (r_tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1)) begin
               w_tmo_err_nxt = 1'b1;
               w_state_nxt   = S_DONE;
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!bus.ctrl_busy) begin
               if (w_last_sym || w_abort_eff) begin
                  w_state_nxt = S_DONE;
               end else if (r_gap == '0) begin
                  w_state_nxt   = S_LAUNCH;
                  w_sym_idx_nxt = r_sym_idx + SYM_W'(1);
               end else begin
                  w_gap_load  = 1'b1;
                  w_state_nxt = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (bus.abort) begin
               w_state_nxt = S_DONE;
            end else if (w_gap_zero) begin
               w_state_nxt   = S_LAUNCH;
               w_sym_idx_nxt = r_sym_idx + SYM_W'(1);
            end else begin
               w_gap_dec = 1'b1;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_abort_pend_nxt = w_abort_eff && (w_state_nxt != S_DONE) && (w_state_nxt != S_IDLE);

   // Loaded with gap-1 so the zero flag marks the last of exactly gap_cycles GAP cycles.
   ofdm_frame_scheduler_down_counter #(.W(GAP_W)) u_gap_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_gap_load),
      .i_load_val (r_gap - GAP_W'(1)),
      .i_dec      (w_gap_dec),
      .o_zero     (w_gap_zero)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_len        <= '0;
         r_gap        <= '0;
         r_sym_idx    <= '0;
         r_tmo_cnt    <= '0;
         r_abort_pend <= 1'b0;
         r_go         <= 1'b0;
         r_ack        <= 1'b0;
         r_active     <= 1'b0;
         r_done       <= 1'b0;
         r_aborted    <= 1'b0;
         r_tmo_err    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sym_idx    <= w_sym_idx_nxt;
         r_tmo_cnt    <= w_tmo_cnt_nxt;
         r_abort_pend <= w_abort_pend_nxt;
         r_tmo_err    <= w_tmo_err_nxt;
         if (w_ack_nxt) begin
            r_len <= bus.frame_len;
            r_gap <= bus.gap_cycles;
         end
         r_go      <= (w_state_nxt == S_LAUNCH);
         r_ack     <= w_ack_nxt;
         r_active  <= (r_state != S_IDLE) && (w_state_nxt != S_IDLE);
         r_done    <= (w_state_nxt == S_DONE);
         r_aborted <= (w_state_nxt == S_DONE) && w_abort_eff;
      end
   end

   assign bus.ctrl_go       = r_go;
   assign bus.frame_ack     = r_ack;
   assign bus.frame_active  = r_active;
   assign bus.sym_idx       = r_sym_idx;
   assign bus.frame_done    = r_done;
   assign bus.frame_aborted = r_aborted;
   assign bus.timeout_err   = r_tmo_err;

endmodule
